// File: rtl/resp_checker_fifo.sv
// resp_checker_fifo
// Response checker for the wave generator environment. Expected characters
// are queued in an internal FIFO by the stimulus side. Each received
// character, qualified by a rising edge of rx_strobe, is compared against
// the FIFO head. The block keeps match, mismatch and framing-error
// statistics plus sticky error flags for the status readout.
//
// Ports
//   clk_rx, rst_clk_rx_n        : clock, asynchronous active-low reset
//   enable                      : checking active
//   exp_push, exp_data, flush   : expected-FIFO write side (flush wins)
//   rx_strobe, rx_data, frm_err : receiver side (edge-qualified levels)
//   clear_cnt                   : clear counters and sticky flags
//   fifo_level/full/empty       : FIFO occupancy
//   chk_valid, chk_err          : one-cycle compare result
//   last_exp, last_rcv          : operands of the last compare
//   match/mismatch/frm_err_cnt  : saturating statistics counters
//   ovf/udf/ovr_sticky          : overflow, underflow, overrun flags
//   done_ok                     : enabled, drained, idle, no sticky flags
module resp_checker_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_rx,
    input  logic                  rst_clk_rx_n,
    input  logic                  enable,
    input  logic                  exp_push,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic                  flush,
    input  logic                  rx_strobe,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  frm_err,
    input  logic                  clear_cnt,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  chk_valid,
    output logic                  chk_err,
    output logic [DATA_WIDTH-1:0] last_exp,
    output logic [DATA_WIDTH-1:0] last_rcv,
    output logic [CNT_WIDTH-1:0]  match_cnt,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt,
    output logic [CNT_WIDTH-1:0]  frm_err_cnt,
    output logic                  ovf_sticky,
    output logic                  udf_sticky,
    output logic                  ovr_sticky,
    output logic                  done_ok
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, SAMPLE, REPORT} state_t;

    state_t                  state, state_nx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic                    strobe_d, frm_d;
    logic                    udf_pend;       // compare started on an empty FIFO
    logic                    strobe_edge, frm_edge, start, pop, push_ok;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign strobe_edge = rx_strobe & ~strobe_d;
    assign frm_edge    = frm_err & ~frm_d;
    assign start       = (state == IDLE) & strobe_edge & enable;
    assign pop         = start & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a push while full still fits.
    assign push_ok     = exp_push & ~flush & (~fifo_full | pop);

    assign fifo_full  = (fifo_level == (DEPTH_LOG2+1)'(DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign chk_valid  = (state == REPORT);
    assign chk_err    = chk_valid & ((last_rcv != last_exp) | udf_pend);
    assign done_ok    = enable & fifo_empty & (state == IDLE) &
                        ~(ovf_sticky | udf_sticky | ovr_sticky);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SAMPLE;
            SAMPLE:  state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage carries no reset; validity is tracked by the pointers/level.
    always_ff @(posedge clk_rx) begin
        if (push_ok) mem[wr_ptr] <= exp_data;
    end

    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            state    <= IDLE;
            strobe_d <= 1'b0;
            frm_d    <= 1'b0;
            udf_pend <= 1'b0;
            last_exp <= '0;
            last_rcv <= '0;
        end else begin
            state    <= state_nx;
            strobe_d <= rx_strobe;
            frm_d    <= frm_err;
            if (start) begin
                last_exp <= pop ? mem[rd_ptr] : '0;
                udf_pend <= ~pop;
            end
            // Data sampled one cycle after the edge for data-valid margin.
            if (state == SAMPLE) last_rcv <= rx_data;
        end
    end

    // Statistics; clear_cnt overrides any increment or flag set that cycle.
    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            frm_err_cnt  <= '0;
            ovf_sticky   <= 1'b0;
            udf_sticky   <= 1'b0;
            ovr_sticky   <= 1'b0;
        end else if (clear_cnt) begin
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            frm_err_cnt  <= '0;
            ovf_sticky   <= 1'b0;
            udf_sticky   <= 1'b0;
            ovr_sticky   <= 1'b0;
        end else begin
            if (chk_valid & ~chk_err) match_cnt    <= sat_inc(match_cnt);
            if (chk_err)              mismatch_cnt <= sat_inc(mismatch_cnt);
            if (frm_edge & enable)    frm_err_cnt  <= sat_inc(frm_err_cnt);
            if (exp_push & ~flush & fifo_full & ~pop) ovf_sticky <= 1'b1;
            if (start & fifo_empty)                   udf_sticky <= 1'b1;
            if (strobe_edge & (state != IDLE))        ovr_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_resp_checker_fifo.sv
// Bench for resp_checker_fifo: two instances (16-bit and 2-bit counters)
// share all inputs. A queue-based model predicts every output each cycle;
// directed scenarios add literal expectations that pin the model.
module tb_resp_checker_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, exp_push, flush, rx_strobe, frm_err, clear_cnt;
    logic [7:0] exp_data, rx_data;

    logic [4:0]  lvl_a, lvl_b;
    logic        full_a, full_b, empty_a, empty_b, val_a, val_b, err_a, err_b;
    logic [7:0]  lexp_a, lexp_b, lrcv_a, lrcv_b;
    logic [15:0] mat_a, mis_a, frm_a;
    logic [1:0]  mat_b, mis_b, frm_b;
    logic        ovf_a, ovf_b, udf_a, udf_b, ovr_a, ovr_b, done_a, done_b;

    int errors = 0;
    int checks = 0;
    int nvalid = 0;

    always #5 clk = ~clk;

    resp_checker_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .CNT_WIDTH(16)) dut_a (
        .clk_rx(clk), .rst_clk_rx_n(rst_n), .enable(enable), .exp_push(exp_push),
        .exp_data(exp_data), .flush(flush), .rx_strobe(rx_strobe), .rx_data(rx_data),
        .frm_err(frm_err), .clear_cnt(clear_cnt), .fifo_level(lvl_a), .fifo_full(full_a),
        .fifo_empty(empty_a), .chk_valid(val_a), .chk_err(err_a), .last_exp(lexp_a),
        .last_rcv(lrcv_a), .match_cnt(mat_a), .mismatch_cnt(mis_a), .frm_err_cnt(frm_a),
        .ovf_sticky(ovf_a), .udf_sticky(udf_a), .ovr_sticky(ovr_a), .done_ok(done_a));

    resp_checker_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .CNT_WIDTH(2)) dut_b (
        .clk_rx(clk), .rst_clk_rx_n(rst_n), .enable(enable), .exp_push(exp_push),
        .exp_data(exp_data), .flush(flush), .rx_strobe(rx_strobe), .rx_data(rx_data),
        .frm_err(frm_err), .clear_cnt(clear_cnt), .fifo_level(lvl_b), .fifo_full(full_b),
        .fifo_empty(empty_b), .chk_valid(val_b), .chk_err(err_b), .last_exp(lexp_b),
        .last_rcv(lrcv_b), .match_cnt(mat_b), .mismatch_cnt(mis_b), .frm_err_cnt(frm_b),
        .ovf_sticky(ovf_b), .udf_sticky(udf_b), .ovr_sticky(ovr_b), .done_ok(done_b));

    // Model state: expected queue, compare phase (0 idle, 1 sampling, 2 reporting),
    // unbounded event counts that are saturated only when compared.
    logic [7:0] q[$];
    int         m_phase, m_match, m_mis, m_frm;
    logic [7:0] m_exp, m_rcv;
    bit         m_udf_pend, m_ovf, m_udf, m_ovr, p_strobe, p_frm;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_phase = 0; m_match = 0; m_mis = 0; m_frm = 0;
        m_exp = 8'h00; m_rcv = 8'h00;
        m_udf_pend = 0; m_ovf = 0; m_udf = 0; m_ovr = 0; p_strobe = 0; p_frm = 0;
    endfunction

    function automatic void model_step();
        bit e, fe, st, pv, rep, er;
        int n;
        e   = rx_strobe && !p_strobe;
        fe  = frm_err && !p_frm;
        rep = (m_phase == 2);
        er  = (m_rcv != m_exp) || m_udf_pend;
        st  = (m_phase == 0) && e && enable;
        n   = q.size();
        pv  = st && (n > 0);
        if (clear_cnt) begin
            m_match = 0; m_mis = 0; m_frm = 0; m_ovf = 0; m_udf = 0; m_ovr = 0;
        end else begin
            if (rep) begin
                if (er) m_mis++;
                else    m_match++;
            end
            if (fe && enable) m_frm++;
            if (e && m_phase != 0) m_ovr = 1;
            if (st && !pv) m_udf = 1;
            if (exp_push && !flush && n == 16 && !pv) m_ovf = 1;
        end
        if (st) begin
            m_exp      = pv ? q[0] : 8'h00;
            m_udf_pend = !pv;
        end
        if (m_phase == 1) m_rcv = rx_data;
        if (flush) q.delete();
        else begin
            if (pv) void'(q.pop_front());
            if (exp_push && (n < 16 || pv)) q.push_back(exp_data);
        end
        if (m_phase == 1)      m_phase = 2;
        else if (m_phase == 2) m_phase = 0;
        else                   m_phase = st ? 1 : 0;
        p_strobe = rx_strobe;
        p_frm    = frm_err;
    endfunction

    function automatic void compare_all();
        bit mv, me, sticky;
        mv     = (m_phase == 2);
        me     = mv && ((m_rcv != m_exp) || m_udf_pend);
        sticky = m_ovf || m_udf || m_ovr;
        if (val_a) nvalid++;
        check("fifo_level",   32'(lvl_a),   32'(q.size()));
        check("fifo_level_b", 32'(lvl_b),   32'(q.size()));
        check("fifo_full",    32'(full_a),  32'(q.size() == 16));
        check("fifo_empty",   32'(empty_a), 32'(q.size() == 0));
        check("chk_valid",    32'(val_a),   32'(mv));
        check("chk_valid_b",  32'(val_b),   32'(mv));
        check("chk_err",      32'(err_a),   32'(me));
        check("last_exp",     32'(lexp_a),  32'(m_exp));
        check("last_rcv",     32'(lrcv_a),  32'(m_rcv));
        check("match_cnt",    32'(mat_a),   32'(sat(m_match, 65535)));
        check("mismatch_cnt", 32'(mis_a),   32'(sat(m_mis, 65535)));
        check("frm_err_cnt",  32'(frm_a),   32'(sat(m_frm, 65535)));
        check("match_cnt_b",  32'(mat_b),   32'(sat(m_match, 3)));
        check("mismatch_b",   32'(mis_b),   32'(sat(m_mis, 3)));
        check("frm_err_b",    32'(frm_b),   32'(sat(m_frm, 3)));
        check("ovf_sticky",   32'(ovf_a),   32'(m_ovf));
        check("udf_sticky",   32'(udf_a),   32'(m_udf));
        check("ovr_sticky",   32'(ovr_a),   32'(m_ovr));
        check("done_ok",      32'(done_a),  32'(enable && q.size() == 0 && m_phase == 0 && !sticky));
    endfunction

    // Compare mid-cycle, advance the model at the edge, drive inputs 2 units later.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #2;
    endtask

    task automatic push(input logic [7:0] d);
        exp_push = 1'b1; exp_data = d; tick(); exp_push = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] d);
        rx_strobe = 1'b1; rx_data = d; tick(); rx_strobe = 1'b0; tick(); tick();
    endtask

    task automatic pulse_clear();
        clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1; tick(); flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; exp_push = 1'b0; flush = 1'b0; rx_strobe = 1'b0;
        frm_err = 1'b0; clear_cnt = 1'b0; exp_data = 8'h00; rx_data = 8'h00;
        model_reset();
        #1;
        check("rst_empty", 32'(empty_a), 32'd1);
        check("rst_level", 32'(lvl_a), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        enable = 1'b1;
        tick();

        // 1: three matches
        nvalid = 0;
        push(8'h41); push(8'h42); push(8'h43);
        strobe(8'h41); strobe(8'h42); strobe(8'h43);
        check("t1_nvalid", 32'(nvalid), 32'd3);
        check("t1_match", 32'(mat_a), 32'd3);
        check("t1_done", 32'(done_a), 32'd1);

        // 2: mismatch
        push(8'h55); strobe(8'h5A);
        check("t2_exp", 32'(lexp_a), 32'h55);
        check("t2_rcv", 32'(lrcv_a), 32'h5A);
        check("t2_mis", 32'(mis_a), 32'd1);

        // enable low: edge ignored
        enable = 1'b0; strobe(8'h00); enable = 1'b1;
        check("ign_udf", 32'(udf_a), 32'd0);

        // 3: underflow, then clear
        pulse_clear();
        strobe(8'h77);
        check("t3_udf", 32'(udf_a), 32'd1);
        check("t3_mis", 32'(mis_a), 32'd1);
        check("t3_exp", 32'(lexp_a), 32'h00);
        check("t3_done", 32'(done_a), 32'd0);
        pulse_clear();
        check("t3_clr", 32'(mat_a) + 32'(mis_a) + 32'(frm_a), 32'd0);
        check("t3_done2", 32'(done_a), 32'd1);

        // 4: overflow, push+pop while full, 16 matches
        for (int i = 0; i < 17; i++) push(8'(i));
        check("t4_full", 32'(full_a), 32'd1);
        check("t4_ovf", 32'(ovf_a), 32'd1);
        exp_push = 1'b1; exp_data = 8'h99; rx_strobe = 1'b1; rx_data = 8'h00;
        tick();
        exp_push = 1'b0; rx_strobe = 1'b0;
        check("t4_pp_lvl", 32'(lvl_a), 32'd16);
        tick(); tick();
        for (int i = 1; i < 16; i++) strobe(8'(i));
        check("t4_match", 32'(mat_a), 32'd16);
        check("t4_lvl", 32'(lvl_a), 32'd1);
        exp_push = 1'b1; exp_data = 8'hEE; pulse_flush(); exp_push = 1'b0;
        check("t4_flush", 32'(lvl_a), 32'd0);
        pulse_clear();

        // 5: overrun and framing errors
        push(8'hA1); push(8'hA2);
        rx_data = 8'hA1;
        rx_strobe = 1'b1; tick(); rx_strobe = 1'b0; tick();
        rx_strobe = 1'b1; tick(); rx_strobe = 1'b0; tick(); tick();
        check("t5_ovr", 32'(ovr_a), 32'd1);
        check("t5_match", 32'(mat_a), 32'd1);
        check("t5_lvl", 32'(lvl_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            frm_err = 1'b1; tick(); frm_err = 1'b0; tick();
        end
        enable = 1'b0; frm_err = 1'b1; tick(); frm_err = 1'b0; tick(); enable = 1'b1;
        check("t5_frm", 32'(frm_a), 32'd3);
        pulse_flush(); pulse_clear();

        // enable dropped mid-compare: compare still completes
        push(8'hB1);
        rx_strobe = 1'b1; rx_data = 8'hB1; tick();
        rx_strobe = 1'b0; enable = 1'b0; tick(); tick();
        check("en_mid", 32'(mat_a), 32'd1);
        enable = 1'b1;

        // 6: reset while sampling, then saturation of the 2-bit counters
        push(8'h66);
        rx_strobe = 1'b1; rx_data = 8'h66; tick();
        rx_strobe = 1'b0;
        rst_n = 1'b0; model_reset();
        #1;
        check("t6_rst_val", 32'(val_a), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("t6_lvl", 32'(lvl_a), 32'd0);
        check("t6_match", 32'(mat_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h30 + i)); strobe(8'(8'h30 + i));
        end
        check("t6_sat_b", 32'(mat_b), 32'd3);
        check("t6_match_a", 32'(mat_a), 32'd5);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
